// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM state encoding and a legality helper.
// Used by both the ALU control unit and the execute-stage ALU.
package alu_pkg;

  localparam int ALU_CTL_W = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'd12;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL = 4'd13;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic alu_ctl_legal(input logic [ALU_CTL_W-1:0] ctl);
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the multi-cycle controller (master) and the ALU (slave).
interface alu_exec_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  import alu_pkg::*;

  logic                 start;
  logic [ALU_CTL_W-1:0] alu_ctl;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [SHAMT_W-1:0]   shamt;
  logic                 busy;
  logic                 done;
  logic [DATA_W-1:0]    result;
  logic                 zero;
  logic                 illegal_op;

  modport master (
    output start, alu_ctl, a, b, shamt,
    input  busy, done, result, zero, illegal_op
  );

  modport slave (
    input  start, alu_ctl, a, b, shamt,
    output busy, done, result, zero, illegal_op
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative left shifter: one bit per cycle, with a strobe on the final step.
module alu_serial_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  output logic [DATA_W-1:0]  next_o,
  output logic               last_o
);

  logic [DATA_W-1:0]  sh_q;
  logic [SHAMT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i;
      cnt_q <= amt_i;
    end else if (shift_i) begin
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  // next_o is the value sh_q takes this cycle, so on the final step it is the full result.
  assign next_o = sh_q << 1;
  assign last_o = shift_i && (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, multi-cycle sll via a serial shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  alu_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              zero_q;
  logic              illegal_q;
  logic [DATA_W-1:0] result_q;

  logic [DATA_W-1:0] op_result_d;
  logic              op_illegal_d;
  logic              is_serial;
  logic              shift_load;
  logic              shift_en;
  logic [DATA_W-1:0] sh_next;
  logic              sh_last;

  // A zero-amount sll needs no iteration and goes through the single-cycle path.
  assign is_serial  = (bus.alu_ctl == ALU_SLL) && (bus.shamt != '0);
  assign shift_load = (state_q == ST_IDLE) && bus.start && is_serial;
  assign shift_en   = (state_q == ST_SHIFT);

  always_comb begin
    op_result_d  = '0;
    op_illegal_d = !alu_ctl_legal(bus.alu_ctl);
    case (bus.alu_ctl)
      ALU_AND: op_result_d = bus.a & bus.b;
      ALU_OR:  op_result_d = bus.a | bus.b;
      ALU_ADD: op_result_d = bus.a + bus.b;
      ALU_SUB: op_result_d = bus.a - bus.b;
      ALU_SLT: op_result_d = {{(DATA_W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_NOR: op_result_d = ~(bus.a | bus.b);
      ALU_SLL: op_result_d = bus.b << bus.shamt;
      default: op_result_d = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (shift_load),
    .shift_i (shift_en),
    .data_i  (bus.b),
    .amt_i   (bus.shamt),
    .next_o  (sh_next),
    .last_o  (sh_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_serial) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              result_q  <= op_result_d;
              zero_q    <= (op_result_d == '0);
              illegal_q <= op_illegal_d;
              done_q    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_last) begin
            result_q  <= sh_next;
            zero_q    <= (sh_next == '0);
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, randomized ops against a model, corner sequences.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_exec_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic over 2^32, shift as multiply by a power of two.
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] s, output logic [31:0] r, output logic ill,
                                output int lat);
    longint unsigned m;
    longint unsigned xu;
    longint unsigned yu;
    m   = 64'h1_0000_0000;
    xu  = {32'd0, x};
    yu  = {32'd0, y};
    ill = 1'b0;
    lat = 1;
    r   = 32'd0;
    case (c)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = 32'((xu + yu) % m);
      4'd6:  r = 32'((xu + m - yu) % m);
      4'd7:  r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd12: r = ~(x | y);
      4'd13: begin
        r   = 32'((yu * (64'd1 << s)) % m);
        lat = 1 + int'(s);
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input logic [31:0] er,
                        input logic ei, input int el);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = c;
    bus.a       = x;
    bus.b       = y;
    bus.shamt   = s;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 1;
    busy_ok   = 1'b1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.shamt = 5'($urandom);
      @(negedge clk);
      lat++;
    end
    $display("op %s ctl=%0d a=%08h b=%08h sh=%0d -> result=%08h zero=%0b ill=%0b lat=%0d",
             tag, c, x, y, s, bus.result, bus.zero, bus.illegal_op, lat);
    check({tag, " latency"}, lat, el);
    check({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " result"}, bus.result, er);
    check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
    check({tag, " illegal"}, {31'd0, bus.illegal_op}, {31'd0, ei});
    @(negedge clk);
    check({tag, " done_single"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  codes[8];
    logic [3:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  s;
    logic [31:0] r;
    logic        il;
    int          lt;
    int          pulses;

    checks = 0;
    errors = 0;

    vecs[0]  = '{4'd2,  32'd5,          32'd7,          5'd0, 32'd12,         1'b0, 1};
    vecs[1]  = '{4'd6,  32'd7,          32'd7,          5'd0, 32'd0,          1'b0, 1};
    vecs[2]  = '{4'd7,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1,          1'b0, 1};
    vecs[3]  = '{4'd7,  32'd1,          32'hFFFF_FFFF,  5'd0, 32'd0,          1'b0, 1};
    vecs[4]  = '{4'd13, 32'd0,          32'h0000_0003,  5'd4, 32'h30,         1'b0, 5};
    vecs[5]  = '{4'd13, 32'd0,          32'h0000_00A5,  5'd0, 32'hA5,         1'b0, 1};
    vecs[6]  = '{4'd5,  32'h1234,       32'h5678,       5'd0, 32'd0,          1'b1, 1};
    vecs[7]  = '{4'd1,  32'h1,          32'h2,          5'd0, 32'd3,          1'b0, 1};
    vecs[8]  = '{4'd0,  32'hF0,         32'h3C,         5'd0, 32'h30,         1'b0, 1};
    vecs[9]  = '{4'd12, 32'd0,          32'd0,          5'd0, 32'hFFFF_FFFF,  1'b0, 1};
    vecs[10] = '{4'd6,  32'd0,          32'd1,          5'd0, 32'hFFFF_FFFF,  1'b0, 1};
    vecs[11] = '{4'd2,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0,          1'b0, 1};

    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd0};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.alu_ctl = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.shamt   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset zero", {31'd0, bus.zero}, 32'd0);
    check("reset illegal", {31'd0, bus.illegal_op}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].sh,
             vecs[i].res, vecs[i].ill, vecs[i].lat);

    // sll with a start pulse arriving while busy, which must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = 4'd13; bus.a = 32'd0; bus.b = 32'h3; bus.shamt = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("busyseq busy k=%0d", k), {31'd0, bus.busy}, {31'd0, (k <= 4)});
      check($sformatf("busyseq done k=%0d", k), {31'd0, bus.done}, {31'd0, (k == 5)});
      if (k == 2) begin
        bus.start = 1'b1; bus.alu_ctl = 4'd2; bus.a = 32'd1; bus.b = 32'd1;
      end
      if (k == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    $display("seq busy-ignore result=%08h", bus.result);
    check("busyseq result", bus.result, 32'h30);

    // back-to-back single-cycle ops
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = 4'd0; bus.a = 32'hF0; bus.b = 32'h3C;
    @(negedge clk);
    check("b2b first done", {31'd0, bus.done}, 32'd1);
    check("b2b first result", bus.result, 32'h30);
    bus.alu_ctl = 4'd12; bus.a = 32'd0; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b second done", {31'd0, bus.done}, 32'd1);
    check("b2b second result", bus.result, 32'hFFFF_FFFF);
    check("b2b second zero", {31'd0, bus.zero}, 32'd0);
    @(negedge clk);
    check("b2b done drops", {31'd0, bus.done}, 32'd0);
    $display("seq back-to-back result=%08h", bus.result);

    // reset in the middle of a long shift
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = 4'd13; bus.b = 32'h1; bus.shamt = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy before reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result, 32'd0);
    check("abort illegal", {31'd0, bus.illegal_op}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort no done", pulses, 32'd0);
    $display("seq reset-abort pulses=%0d", pulses);
    run_op("after_abort", 4'd2, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1);

    for (int i = 0; i < 150; i++) begin
      c = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) c = 4'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? x : $urandom;
      s = 5'($urandom);
      model(c, x, y, s, r, il, lt);
      run_op($sformatf("rand%0d", i), c, x, y, s, r, il, lt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control unit, plus operands A (rs), B (rt) and shamt from the register file and decoder.
- Single-cycle logical, arithmetic and compare ops complete with registered latency 1.
- sll runs on an iterative 1-bit-per-cycle shifter, so the block exposes a start/busy/done handshake that the multi-cycle controller uses to stall.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W >= DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- alu_ctl  input  4  ALU control code.
- a  input  DATA_W  operand A (rs).
- b  input  DATA_W  operand B (rt or immediate).
- shamt  input  SHAMT_W  shift amount for sll.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  DATA_W  registered result; held until next completion.
- zero  output  1  registered (result==0), updated together with result.
- illegal_op  output  1  registered; set with done when alu_ctl is an unsupported code.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, result=0, zero=0, illegal_op=0; shift register and counter cleared. Reset mid-shift aborts the shift with no done pulse.
- Op codes:
  - 0: and, a&b.
  - 1: or, a|b.
  - 2: add, a+b modulo 2^DATA_W, no overflow flag.
  - 6: sub, a-b modulo 2^DATA_W.
  - 7: slt, signed a<b gives 1, else 0, zero-extended.
  - 12: nor, ~(a|b).
  - 13: sll, b<<shamt.
  - Any other code: result=0, illegal_op=1.
- States: IDLE, SHIFT.
- IDLE with start=1 in cycle T:
  - Non-sll op, or sll with shamt=0: result, zero and illegal_op are written at the end of T; done=1 during T+1; state stays IDLE.
  - sll with shamt=n>0: at the end of T, load sh_reg=b and cnt=n, go to SHIFT. busy=1 from T+1.
- SHIFT: each cycle sh_reg<=sh_reg<<1 and cnt<=cnt-1.
  - On the cycle with cnt==1: write result=sh_reg<<1, update zero, clear illegal_op, return to IDLE.
  - busy=0 and done=1 during T+n+1.
- Latency is 1 + (alu_ctl==13 ? shamt : 0) cycles from start to done.
- start while busy=1: ignored. Operands are not re-sampled; a, b and shamt may change freely during SHIFT.
- start in the same cycle done=1 (state IDLE): accepted normally, giving back-to-back single-cycle ops one result per cycle.
- done is never high for more than one consecutive cycle per operation. result, zero and illegal_op hold their values between completions.
- start=0 in IDLE: no state change, outputs hold.
- shamt >= DATA_W cannot occur at the defaults. If parameters allow it, the result is 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_SLL=13.
  - ALU_CTL_W=4.
  - The state encoding for IDLE/SHIFT.
  - The ALU control unit and this block both use these constants.
- One sub-module, alu_serial_shifter, contains sh_reg, cnt and the finish strobe, with load/shift/last ports. The top level contains the combinational op mux, the result registers and the FSM.

Test Plan:
- Reset, then pulse start with alu_ctl=2, a=5, b=7 -> done in the next cycle only, result=12, zero=0, illegal_op=0, busy never high.
- alu_ctl=6, a=7, b=7 -> result=0, zero=1; then alu_ctl=7, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1).
- alu_ctl=13, b=0x00000003, shamt=4, start at cycle T -> busy high T+1..T+4, done only at T+5, result=0x30. A start pulse with alu_ctl=2 during busy is ignored with no extra done.
- alu_ctl=13, shamt=0, b=0xA5 -> done at T+1, result=0xA5. Back-to-back starts on consecutive cycles with and (0xF0&0x3C=0x30) then nor (a=0, b=0 -> 0xFFFFFFFF) -> done high two consecutive cycles with the correct results in order.
- alu_ctl=5 (unsupported) -> done pulse, result=0, illegal_op=1, zero=1. A following alu_ctl=1 op (0x1|0x2) -> result=3, illegal_op=0.
- Start sll with shamt=31, assert reset at T+10 -> next cycle busy=0, done=0, result=0 and no done pulse ever appears; a subsequent add completes normally.
